// File: rtl/leve_irf_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : leve_irf_wb_sched
// Purpose  : Writeback scheduler and RAW/WAW scoreboard for the integer
//            register file. Three writeback sources (LSU, CSR unit, ALU)
//            share the IRF's single write port, granted by fixed priority
//            LSU > CSR > ALU. A starvation counter gives the ALU a forced
//            grant. A busy-bit scoreboard stalls issue while any source or
//            destination register still has a write pending.
// Ports    : CLK, RSTn (async, active-low)
//            FLUSH                    - clear scoreboard, block issue
//            ISSUE_*                  - issue-stage operand/destination info
//            ISSUE_STALL              - combinational hazard stall
//            {LSU,CSR,ALU}_VALID/RD/D - writeback requests
//            {LSU,CSR,ALU}_READY      - combinational one-hot grants
//            RD_WE/RD/RD_D/CSR_WE/CSR_D - registered IRF write port
// Revision : 1.0 - initial release
// ============================================================================
module leve_irf_wb_sched #(
  parameter int XLEN       = 64,
  parameter int NUM_REG    = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            FLUSH,
  input  logic            ISSUE_VALID,
  input  logic            ISSUE_RS1_EN,
  input  logic            ISSUE_RS2_EN,
  input  logic            ISSUE_RD_EN,
  input  logic [4:0]      ISSUE_RS1,
  input  logic [4:0]      ISSUE_RS2,
  input  logic [4:0]      ISSUE_RD,
  output logic            ISSUE_STALL,
  input  logic            LSU_VALID,
  input  logic            CSR_VALID,
  input  logic            ALU_VALID,
  input  logic [4:0]      LSU_RD,
  input  logic [4:0]      CSR_RD,
  input  logic [4:0]      ALU_RD,
  input  logic [XLEN-1:0] LSU_D,
  input  logic [XLEN-1:0] CSR_D_IN,
  input  logic [XLEN-1:0] ALU_D,
  output logic            LSU_READY,
  output logic            CSR_READY,
  output logic            ALU_READY,
  output logic            RD_WE,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] RD_D,
  output logic            CSR_WE,
  output logic [XLEN-1:0] CSR_D
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]   starve_cnt;
  logic [NUM_REG-1:0] busy;
  logic [NUM_REG-1:0] busy_nxt;

  logic alu_force;
  logic lsu_gnt;
  logic csr_gnt;
  logic alu_gnt;
  logic rs1_haz;
  logic rs2_haz;
  logic rd_haz;
  logic issue_acc;

  // --------------------------------------------------------------------------
  // Arbitration: fixed priority, overridden by a starved ALU.
  // --------------------------------------------------------------------------
  assign alu_force = ALU_VALID && (starve_cnt == STARVE_LIM);
  assign lsu_gnt   = LSU_VALID && !alu_force;
  assign csr_gnt   = CSR_VALID && !LSU_VALID && !alu_force;
  assign alu_gnt   = ALU_VALID && (alu_force || (!LSU_VALID && !CSR_VALID));

  assign LSU_READY = lsu_gnt;
  assign CSR_READY = csr_gnt;
  assign ALU_READY = alu_gnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      starve_cnt <= '0;
    end else if (ALU_VALID && !alu_gnt) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write port. Data registers hold when there is no grant, so
  // the IRF sees stable values even while the enables are low.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      RD_WE  <= 1'b0;
      RD     <= '0;
      RD_D   <= '0;
      CSR_WE <= 1'b0;
      CSR_D  <= '0;
    end else begin
      RD_WE  <= 1'b0;
      CSR_WE <= 1'b0;
      if (lsu_gnt) begin
        RD_WE <= (LSU_RD != 5'd0);
        RD    <= LSU_RD;
        RD_D  <= LSU_D;
      end else if (csr_gnt) begin
        RD_WE  <= (CSR_RD != 5'd0);
        RD     <= CSR_RD;
        CSR_D  <= CSR_D_IN;
        CSR_WE <= 1'b1;
      end else if (alu_gnt) begin
        RD_WE <= (ALU_RD != 5'd0);
        RD    <= ALU_RD;
        RD_D  <= ALU_D;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard. A busy bit stays set through the cycle its write is on the
  // port (the IRF read samples on that same edge) and clears at its end.
  // --------------------------------------------------------------------------
  assign rs1_haz = ISSUE_RS1_EN && (ISSUE_RS1 != 5'd0) && busy[ISSUE_RS1];
  assign rs2_haz = ISSUE_RS2_EN && (ISSUE_RS2 != 5'd0) && busy[ISSUE_RS2];
  assign rd_haz  = ISSUE_RD_EN  && (ISSUE_RD  != 5'd0) && busy[ISSUE_RD];

  assign ISSUE_STALL = ISSUE_VALID && (FLUSH || rs1_haz || rs2_haz || rd_haz);
  assign issue_acc   = ISSUE_VALID && !ISSUE_STALL && ISSUE_RD_EN && (ISSUE_RD != 5'd0);

  always_comb begin
    busy_nxt = busy;
    if (FLUSH) begin
      busy_nxt = '0;
    end else if (RD_WE) begin
      busy_nxt[RD] = 1'b0;
    end
    // Applied after the clear: a newly issued producer is younger than the
    // write retiring on the same edge, so its busy bit must survive.
    if (issue_acc) begin
      busy_nxt[ISSUE_RD] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_leve_irf_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_leve_irf_wb_sched
// Purpose  : Self-checking bench for leve_irf_wb_sched. Directed scenarios
//            with literal expectations, then randomized traffic compared
//            every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leve_irf_wb_sched;

  localparam int XLEN       = 64;
  localparam int NUM_REG    = 32;
  localparam int STARVE_MAX = 4;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic FLUSH, ISSUE_VALID, ISSUE_RS1_EN, ISSUE_RS2_EN, ISSUE_RD_EN;
  logic [4:0] ISSUE_RS1, ISSUE_RS2, ISSUE_RD;
  logic ISSUE_STALL;
  logic LSU_VALID, CSR_VALID, ALU_VALID;
  logic [4:0] LSU_RD, CSR_RD, ALU_RD;
  logic [XLEN-1:0] LSU_D, CSR_D_IN, ALU_D;
  logic LSU_READY, CSR_READY, ALU_READY;
  logic RD_WE, CSR_WE;
  logic [4:0] RD;
  logic [XLEN-1:0] RD_D, CSR_D;

  leve_irf_wb_sched #(.XLEN(XLEN), .NUM_REG(NUM_REG), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RSTn(RSTn), .FLUSH(FLUSH),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RS1_EN(ISSUE_RS1_EN), .ISSUE_RS2_EN(ISSUE_RS2_EN),
    .ISSUE_RD_EN(ISSUE_RD_EN), .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2),
    .ISSUE_RD(ISSUE_RD), .ISSUE_STALL(ISSUE_STALL),
    .LSU_VALID(LSU_VALID), .CSR_VALID(CSR_VALID), .ALU_VALID(ALU_VALID),
    .LSU_RD(LSU_RD), .CSR_RD(CSR_RD), .ALU_RD(ALU_RD),
    .LSU_D(LSU_D), .CSR_D_IN(CSR_D_IN), .ALU_D(ALU_D),
    .LSU_READY(LSU_READY), .CSR_READY(CSR_READY), .ALU_READY(ALU_READY),
    .RD_WE(RD_WE), .RD(RD), .RD_D(RD_D), .CSR_WE(CSR_WE), .CSR_D(CSR_D)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: pending-write set, ALU denial count, expected port.
  // --------------------------------------------------------------------------
  bit [31:0]       m_busy   = '0;
  int              m_starve = 0;
  bit              m_we     = 0;
  bit              m_cwe    = 0;
  bit [4:0]        m_rd     = '0;
  bit [XLEN-1:0]   m_d      = '0;
  bit [XLEN-1:0]   m_cd     = '0;

  // 0 none, 1 LSU, 2 CSR, 3 ALU
  function automatic int m_grant();
    if (ALU_VALID && m_starve >= STARVE_MAX) return 3;
    if (LSU_VALID) return 1;
    if (CSR_VALID) return 2;
    if (ALU_VALID) return 3;
    return 0;
  endfunction

  function automatic bit m_pending(input bit en, input bit [4:0] r);
    return en && (r != 0) && m_busy[r];
  endfunction

  function automatic bit m_stall();
    return ISSUE_VALID && (FLUSH || m_pending(ISSUE_RS1_EN, ISSUE_RS1) ||
           m_pending(ISSUE_RS2_EN, ISSUE_RS2) || m_pending(ISSUE_RD_EN, ISSUE_RD));
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_busy = '0; m_starve = 0; m_we = 0; m_cwe = 0; m_rd = '0; m_d = '0; m_cd = '0;
    end else begin
      int  g;
      bit  acc;
      g   = m_grant();
      acc = ISSUE_VALID && !m_stall() && ISSUE_RD_EN && (ISSUE_RD != 0);
      if (FLUSH) m_busy = '0;
      else if (m_we) m_busy[m_rd] = 1'b0;
      if (acc) m_busy[ISSUE_RD] = 1'b1;
      if (ALU_VALID && g != 3) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
      else m_starve = 0;
      m_we = 0; m_cwe = 0;
      case (g)
        1: begin m_we = (LSU_RD != 0); m_rd = LSU_RD; m_d  = LSU_D; end
        2: begin m_we = (CSR_RD != 0); m_rd = CSR_RD; m_cd = CSR_D_IN; m_cwe = 1; end
        3: begin m_we = (ALU_RD != 0); m_rd = ALU_RD; m_d  = ALU_D; end
        default: ;
      endcase
    end
  end

  // Single compare process, mid-cycle away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      int g;
      g = m_grant();
      check("m_lsu_ready", LSU_READY, (g == 1));
      check("m_csr_ready", CSR_READY, (g == 2));
      check("m_alu_ready", ALU_READY, (g == 3));
      check("m_stall", ISSUE_STALL, m_stall());
      check("m_rd_we", RD_WE, m_we);
      check("m_csr_we", CSR_WE, m_cwe);
      check("m_rd", RD, m_rd);
      check("m_rd_d", RD_D, m_d);
      check("m_csr_d", CSR_D, m_cd);
    end
  end

  task automatic nxt();
    @(posedge CLK); #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic issue(input bit v, input bit e1, input bit [4:0] r1, input bit ed, input bit [4:0] rd);
    ISSUE_VALID = v; ISSUE_RS1_EN = e1; ISSUE_RS1 = r1; ISSUE_RD_EN = ed; ISSUE_RD = rd;
    ISSUE_RS2_EN = 0; ISSUE_RS2 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit l_done, c_done, a_done;
    FLUSH = 0; issue(0, 0, 0, 0, 0);
    LSU_VALID = 0; CSR_VALID = 0; ALU_VALID = 0;
    LSU_RD = 0; CSR_RD = 0; ALU_RD = 0; LSU_D = 0; CSR_D_IN = 0; ALU_D = 0;
    chk_en = 1;
    repeat (2) @(posedge CLK);
    mid();
    check("rst_rd_we", RD_WE, 0); check("rst_csr_we", CSR_WE, 0);
    check("rst_rd_d", RD_D, 0);   check("rst_csr_d", CSR_D, 0);
    nxt(); RSTn = 1;

    // Single ALU write
    ALU_VALID = 1; ALU_RD = 5; ALU_D = 64'h1234;
    mid(); check("t1_alu_ready", ALU_READY, 1);
    nxt(); ALU_VALID = 0;
    mid(); check("t1_rd_we", RD_WE, 1); check("t1_rd", RD, 5);
    check("t1_rd_d", RD_D, 64'h1234); check("t1_csr_we", CSR_WE, 0);
    nxt(); mid(); check("t1_rd_we_off", RD_WE, 0);

    // Three-way contention
    nxt();
    LSU_VALID = 1; LSU_RD = 3; LSU_D = 64'h33;
    CSR_VALID = 1; CSR_RD = 4; CSR_D_IN = 64'h44;
    ALU_VALID = 1; ALU_RD = 5; ALU_D = 64'h55;
    mid(); check("t2_c0_lsu", LSU_READY, 1); check("t2_c0_alu", ALU_READY, 0);
    nxt(); LSU_VALID = 0;
    mid(); check("t2_c1_csr", CSR_READY, 1); check("t2_c1_rd", RD, 3); check("t2_c1_cwe", CSR_WE, 0);
    nxt(); CSR_VALID = 0;
    mid(); check("t2_c2_alu", ALU_READY, 1); check("t2_c2_cwe", CSR_WE, 1);
    check("t2_c2_cd", CSR_D, 64'h44); check("t2_c2_rd", RD, 4);
    nxt(); ALU_VALID = 0;
    mid(); check("t2_c3_cwe", CSR_WE, 0); check("t2_c3_rd", RD, 5); check("t2_c3_d", RD_D, 64'h55);

    // Starvation
    nxt();
    LSU_VALID = 1; LSU_RD = 7; LSU_D = 64'h77;
    ALU_VALID = 1; ALU_RD = 8; ALU_D = 64'h88;
    for (int c = 0; c < 4; c++) begin
      mid(); check("t3_denied", ALU_READY, 0); check("t3_lsu", LSU_READY, 1);
      nxt();
    end
    mid(); check("t3_forced", ALU_READY, 1); check("t3_lsu_held", LSU_READY, 0);
    nxt(); ALU_VALID = 0;
    mid(); check("t3_lsu_resume", LSU_READY, 1); check("t3_rd8", RD, 8);
    nxt(); LSU_VALID = 0;

    // RAW
    issue(1, 0, 0, 1, 9);
    mid(); check("t4_acc", ISSUE_STALL, 0);
    nxt(); issue(1, 1, 9, 0, 0); LSU_VALID = 1; LSU_RD = 9; LSU_D = 64'h99;
    mid(); check("t4_stall_a", ISSUE_STALL, 1); check("t4_lsu", LSU_READY, 1);
    nxt(); LSU_VALID = 0;
    mid(); check("t4_stall_we", ISSUE_STALL, 1); check("t4_rd_we", RD_WE, 1); check("t4_rd", RD, 9);
    nxt(); mid(); check("t4_release", ISSUE_STALL, 0);

    // Same-edge set/clear
    nxt(); issue(0, 0, 0, 0, 0); LSU_VALID = 1; LSU_RD = 10; LSU_D = 64'hA0;
    mid(); check("t5_lsu", LSU_READY, 1);
    nxt(); LSU_VALID = 0; issue(1, 0, 0, 1, 10);
    mid(); check("t5_rd_we", RD_WE, 1); check("t5_rd", RD, 10); check("t5_acc", ISSUE_STALL, 0);
    nxt(); issue(1, 1, 10, 0, 0);
    mid(); check("t5_set_wins", ISSUE_STALL, 1);

    // FLUSH then asynchronous reset during a pending grant
    nxt(); issue(1, 0, 0, 1, 6);
    mid(); check("t6_acc", ISSUE_STALL, 0);
    nxt(); issue(1, 1, 6, 0, 0);
    mid(); check("t6_busy", ISSUE_STALL, 1);
    nxt(); FLUSH = 1; LSU_VALID = 1; LSU_RD = 11; LSU_D = 64'hB;
    mid(); check("t6_flush_stall", ISSUE_STALL, 1); check("t6_lsu", LSU_READY, 1);
    nxt(); FLUSH = 0; LSU_VALID = 0;
    mid(); check("t6_cleared", ISSUE_STALL, 0); check("t6_inflight", RD_WE, 1); check("t6_rd", RD, 11);
    nxt(); issue(0, 0, 0, 0, 0); CSR_VALID = 1; CSR_RD = 12; CSR_D_IN = 64'hC5;
    mid(); check("t6_csr", CSR_READY, 1);
    nxt(); CSR_VALID = 0; ALU_VALID = 1; ALU_RD = 13; ALU_D = 64'hA1;
    mid(); check("t6_cwe", CSR_WE, 1); check("t6_cd", CSR_D, 64'hC5); check("t6_alu", ALU_READY, 1);
    #1 RSTn = 0;
    #1 check("t6_rst_we", RD_WE, 0); check("t6_rst_cwe", CSR_WE, 0);
    check("t6_rst_rd", RD, 0); check("t6_rst_cd", CSR_D, 0);
    nxt(); ALU_VALID = 0; RSTn = 1;
    mid(); check("t6_dropped", RD_WE, 0); check("t6_dropped_d", RD_D, 0);

    // Randomized traffic, model-checked every cycle
    l_done = 0; c_done = 0; a_done = 0;
    for (int c = 0; c < 3000; c++) begin
      nxt();
      if (!LSU_VALID || l_done) begin
        LSU_VALID = ($urandom_range(0, 2) != 0);
        LSU_RD = 5'($urandom_range(0, 7)); LSU_D = {$urandom, $urandom};
      end
      if (!CSR_VALID || c_done) begin
        CSR_VALID = ($urandom_range(0, 3) == 0);
        CSR_RD = 5'($urandom_range(0, 7)); CSR_D_IN = {$urandom, $urandom};
      end
      if (!ALU_VALID || a_done) begin
        ALU_VALID = ($urandom_range(0, 1) != 0);
        ALU_RD = 5'($urandom_range(0, 7)); ALU_D = {$urandom, $urandom};
      end
      ISSUE_VALID  = ($urandom_range(0, 1) != 0);
      ISSUE_RS1_EN = $urandom_range(0, 1) != 0; ISSUE_RS1 = 5'($urandom_range(0, 7));
      ISSUE_RS2_EN = $urandom_range(0, 1) != 0; ISSUE_RS2 = 5'($urandom_range(0, 7));
      ISSUE_RD_EN  = $urandom_range(0, 1) != 0; ISSUE_RD  = 5'($urandom_range(0, 7));
      FLUSH = ($urandom_range(0, 39) == 0);
      mid();
      l_done = LSU_VALID && LSU_READY;
      c_done = CSR_VALID && CSR_READY;
      a_done = ALU_VALID && ALU_READY;
    end

    nxt();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
